// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the MEM stage: FSM encoding, memory depth
// and the bit positions of the WB control pair carried through EX/MEM and MEM/WB.
package mem_stage_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } mem_state_t;

    localparam int unsigned MEM_WORDS_DEFAULT = 256;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Single-port data memory: synchronous write, registered (1-cycle) read.
// Contents start at zero and are never cleared by reset.
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [MEM_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        if (re) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, data-memory access with a one-cycle
// load stall, and the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctlout,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] add_result,
    input  logic [31:0] alu_result,
    input  logic        zero,
    input  logic [31:0] rdata2out,
    input  logic [4:0]  five_bit_muxout,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic        mem_err,
    output logic [1:0]  wb_out,
    output logic [31:0] read_data,
    output logic [31:0] alu_pass,
    output logic [4:0]  wr_reg
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    mem_state_t  state, state_n;
    logic        aligned;
    logic        mem_re, mem_we;
    logic [31:0] mem_dout;
    logic [1:0]  wb_n;
    logic [31:0] rd_n, alu_n;
    logic [4:0]  reg_n;
    logic        err_n;

    assign pcsrc         = branch & zero & ~rst;
    assign branch_target = add_result;
    assign aligned       = (alu_result[1:0] == 2'b00);

    data_memory #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_dmem (
        .clk  (clk),
        .we   (mem_we),
        .re   (mem_re),
        .addr (alu_result[AW+1:2]),
        .din  (rdata2out),
        .dout (mem_dout)
    );

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        wb_n    = '0;
        rd_n    = '0;
        alu_n   = '0;
        reg_n   = '0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if ((memread || memwrite) && !aligned) begin
                    err_n = 1'b1;
                    alu_n = alu_result;
                    reg_n = five_bit_muxout;
                end else if (memread) begin
                    // Read wins over a simultaneous write; the write is dropped
                    // and flagged when the load result lands.
                    stall   = 1'b1;
                    mem_re  = ~rst;
                    state_n = RD_WAIT;
                end else begin
                    mem_we = memwrite & ~rst;
                    wb_n   = wb_ctlout;
                    alu_n  = alu_result;
                    reg_n  = five_bit_muxout;
                end
            end
            RD_WAIT: begin
                wb_n    = wb_ctlout;
                rd_n    = mem_dout;
                alu_n   = alu_result;
                reg_n   = five_bit_muxout;
                err_n   = memwrite;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wb_out    <= '0;
            read_data <= '0;
            alu_pass  <= '0;
            wr_reg    <= '0;
            mem_err   <= 1'b0;
        end else begin
            state     <= state_n;
            wb_out    <= wb_n;
            read_data <= rd_n;
            alu_pass  <= alu_n;
            wr_reg    <= reg_n;
            mem_err   <= err_n;
        end
    end

endmodule
